result_frame_writer: RTL and testbench

//  Downstream consumer of result_address_lookup. Requests a result slot by pulsing slot_req
//  (wired to the lookup's inc_addr) and latches the slot base from base_addr/base_valid
//  (wired to addr_out/write_enable). Streams one matched Ethernet frame into the slot as 32-bit

---
 rtl/result_frame_writer.sv | 158 +++++++++++++++
 tb/tb_result_frame_writer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/result_frame_writer.sv
// result_frame_writer: streams one matched frame into a result slot, then writes its length/status word
//
// Requests a slot from the address lookup, latches the slot base, writes each
// accepted 32-bit word at base+4+4*n through a waitrequest-style master, and
// finishes with {ovf, 15'b0, byte_count[15:0]} at the slot base.
//
// Ports
//    clk               system clock, rising edge
//    rst               asynchronous reset, active high
//    in_data_i         frame word from the match stage
//    in_valid_i        in_data_i valid
//    in_last_i         final word of frame (qualified by in_valid_i)
//    in_ready_o        word accepted when in_valid_i && in_ready_o
//    slot_req_o        one-cycle pulse requesting the next slot
//    base_addr_i       slot base byte address
//    base_valid_i      base_addr_i valid strobe
//    mem_addr_o        byte address of current write
//    mem_wdata_o       write data
//    mem_write_o       write request, held with address/data while stalled
//    mem_waitrequest_i slave stall
//    frame_done_o      one-cycle pulse after the length word is accepted
//    busy_o            high in every state except IDLE
module result_frame_writer #(
   parameter int unsigned SLOT_BYTES = 1550,
   parameter int unsigned MAX_WORDS  = (SLOT_BYTES - 4) / 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   input  logic        in_last_i,
   output logic        in_ready_o,
   output logic        slot_req_o,
   input  logic [31:0] base_addr_i,
   input  logic        base_valid_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_write_o,
   input  logic        mem_waitrequest_i,
   output logic        frame_done_o,
   output logic        busy_o
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_SLOT = 3'd1;
   localparam logic [2:0] STREAM    = 3'd2;
   localparam logic [2:0] DROP      = 3'd3;
   localparam logic [2:0] DROP_WAIT = 3'd4;
   localparam logic [2:0] LEN       = 3'd5;
   localparam logic [2:0] DONE      = 3'd6;
   localparam logic [13:0] MAX_CNT  = 14'(MAX_WORDS);

   logic [2:0]  state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [31:0] base_q, base_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic        slot_req_q, slot_req_d;
   logic        done_q, done_d;
   logic        stalled;
   logic        accept;

   assign stalled      = write_q && mem_waitrequest_i;
   // Data words are only taken when the write slot is free or retiring this cycle;
   // DROP discards words, so it never needs to wait on the memory side.
   assign in_ready_o   = (state_q == DROP) || ((state_q == STREAM) && !stalled);
   assign accept       = in_valid_i && in_ready_o;
   assign slot_req_o   = slot_req_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign mem_write_o  = write_q;
   assign frame_done_o = done_q;
   assign busy_o       = state_q != IDLE;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      base_d     = base_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = stalled;
      slot_req_d = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            slot_req_d = in_valid_i;
            state_d    = in_valid_i ? WAIT_SLOT : IDLE;
         end
         WAIT_SLOT: begin
            if (base_valid_i) begin
               base_d  = base_addr_i;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               if (cnt_q < MAX_CNT) begin
                  addr_d  = base_q + 32'd4 + {16'b0, cnt_q, 2'b00};
                  wdata_d = in_data_i;
                  write_d = 1'b1;
                  cnt_d   = cnt_q + 14'd1;
               end else begin
                  ovf_d = 1'b1;
               end
               state_d = in_last_i ? DROP_WAIT : (cnt_q == MAX_CNT) ? DROP : STREAM;
            end
         end
         DROP: begin
            if (accept && in_last_i) state_d = DROP_WAIT;
         end
         DROP_WAIT: begin
            // Length word is issued only after the final data write has retired.
            if (!stalled) begin
               addr_d  = base_q;
               wdata_d = {ovf_q, 15'b0, cnt_q, 2'b00};
               write_d = 1'b1;
               state_d = LEN;
            end
         end
         LEN: begin
            if (!mem_waitrequest_i) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         base_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         slot_req_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         slot_req_q <= slot_req_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: tb/tb_result_frame_writer.sv
// tb_result_frame_writer: randomized frames checked against a slot-image reference model
module tb_result_frame_writer;
   localparam int MAX = 386;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        slot_req;
   logic [31:0] base_addr = '0;
   logic        base_valid = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_waitrequest = 1'b0;
   logic        frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int stall_pct = 0;
   int sreq_cnt = 0;
   int done_cnt = 0;
   logic [63:0] log_q[$];

   result_frame_writer dut (
      .clk(clk), .rst(rst),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
      .slot_req_o(slot_req), .base_addr_i(base_addr), .base_valid_i(base_valid),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
      .mem_waitrequest_i(mem_waitrequest), .frame_done_o(frame_done), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Memory slave: picks waitrequest each cycle, logs retired writes, checks stall hold.
   initial begin
      logic        pstall;
      logic [63:0] pval;
      pstall = 1'b0;
      pval = '0;
      forever begin
         @(negedge clk);
         mem_waitrequest = ($urandom_range(99) < stall_pct);
         #1;
         if (rst) pstall = 1'b0;
         else begin
            if (pstall) check("hold", {mem_write, mem_addr, mem_wdata}, {1'b1, pval});
            if (mem_write && !mem_waitrequest) log_q.push_back({mem_addr, mem_wdata});
            if (slot_req) sreq_cnt++;
            if (frame_done) done_cnt++;
            pstall = mem_write && mem_waitrequest;
            pval = {mem_addr, mem_wdata};
         end
      end
   end

   task automatic run_frame(input logic [31:0] base, input int n, input int sp, input int gap,
                            input int abort_at);
      logic [31:0] w[$];
      int i, cyc, m;
      for (int k = 0; k < n; k++) w.push_back($urandom);
      stall_pct = sp;
      @(negedge clk);
      log_q.delete();
      sreq_cnt = 0;
      done_cnt = 0;
      in_valid = 1'b1;
      in_data = w[0];
      in_last = (n == 1);
      cyc = 0;
      while (sreq_cnt == 0 && cyc < 20) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      check("slot_req_seen", 65'(sreq_cnt), 65'd1);
      repeat ($urandom_range(2)) @(negedge clk);
      @(negedge clk);
      base_valid = 1'b1;
      base_addr = base;
      i = 0;
      cyc = 0;
      while (i < n && cyc < 4000) begin
         @(negedge clk);
         base_valid = 1'b0;
         base_addr = $urandom;
         in_valid = ($urandom_range(99) >= gap);
         in_data = w[i];
         in_last = (i == n - 1);
         #2;
         if (abort_at > 0 && log_q.size() >= abort_at) break;
         if (in_valid && in_ready) i++;
         cyc++;
      end
      if (abort_at > 0) begin
         in_valid = 1'b0;
         in_last = 1'b0;
         check("abort_reached", 65'(log_q.size() >= abort_at), 65'd1);
         #1 rst = 1'b1;
         #1 check("rst_outs", {in_ready, slot_req, mem_write, frame_done, busy, mem_addr, mem_wdata}, '0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         #2 check("post_rst", {busy, slot_req, mem_write, frame_done}, '0);
         return;
      end
      check("accepted", 65'(i), 65'(n));
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < 2000) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      repeat (3) @(negedge clk);
      #2;
      m = (n > MAX) ? MAX : n;
      check("slot_reqs", 65'(sreq_cnt), 65'd1);
      check("frame_done", 65'(done_cnt), 65'd1);
      check("busy_idle", {64'b0, busy}, 65'd0);
      check("n_writes", 65'(log_q.size()), 65'(m + 1));
      for (int k = 0; k < m && k < log_q.size(); k++)
         check("data_wr", {1'b0, log_q[k]}, {1'b0, base + 32'(4 + 4 * k), w[k]});
      if (log_q.size() > m)
         check("len_wr", {1'b0, log_q[m]}, {1'b0, base, n > MAX, 15'b0, 16'(4 * m)});
   endtask

   initial begin
      #1 check("reset_outs", {in_ready, slot_req, mem_write, frame_done, busy, mem_addr, mem_wdata}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2 check("idle_after_rst", {busy, slot_req, in_ready}, '0);
      run_frame(32'h0000_060E, 3, 0, 0, 0);
      run_frame(32'h0000_060E, 3, 50, 0, 0);
      run_frame(32'h0000_0C1C, 400, 20, 10, 0);
      run_frame(32'h0000_122A, 1, 0, 0, 0);
      run_frame(32'h0000_1000, 10, 0, 0, 2);
      run_frame(32'h0000_2000, 1, 30, 0, 0);
      run_frame($urandom, MAX, 25, 20, 0);
      run_frame($urandom, MAX + 1, 25, 20, 0);
      run_frame(32'hFFFF_FFF0, 8, 30, 30, 0);
      for (int r = 0; r < 8; r++)
         run_frame($urandom, $urandom_range(1, 24), $urandom_range(0, 60), $urandom_range(0, 40), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
